// File: rtl/line_scaler.sv
// rtl/line_scaler.sv - ping-pong line buffer scaler replaying lines SCALE_Y times and pixels SCALE_X times
// Optional scanline dimming on the last vertical repetition: define LINE_SCALER_SCANLINE_EN.
module line_scaler #(
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int H_PIXELS = 256,
    parameter int SCALE_X  = 2,
    parameter int SCALE_Y  = 2
) (
    input  logic           masterclk,
    input  logic           rst_n,
    input  logic           in_pix_en,
    input  logic           in_valid,
    input  logic [R_W-1:0] in_r,
    input  logic [G_W-1:0] in_g,
    input  logic [B_W-1:0] in_b,
    input  logic           out_pix_en,
    input  logic           out_line_start,
    input  logic           out_hactive,
    output logic [R_W-1:0] out_r,
    output logic [G_W-1:0] out_g,
    output logic [B_W-1:0] out_b,
    output logic           out_de,
    output logic           underrun,
    output logic           overrun
);
    localparam int PW = R_W + G_W + B_W;
    localparam int AW = $clog2(H_PIXELS);
    localparam logic [AW:0]   WR_LIMIT = (AW+1)'(H_PIXELS);
    localparam logic [AW-1:0] RD_LAST  = AW'(H_PIXELS - 1);
    localparam logic [2:0]    X_LAST   = 3'(SCALE_X - 1);
    localparam logic [2:0]    Y_LAST   = 3'(SCALE_Y - 1);

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          line_ready_q, line_ready_d;
    logic [AW:0]   wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]    x_rep_q, x_rep_d;
    logic [2:0]    y_rep_q, y_rep_d;
    logic          in_valid_prev_q, in_valid_prev_d;
    logic          shown_q, shown_d;
    logic          out_de_q, out_de_d;
    logic          underrun_q, underrun_d;
    logic          overrun_q, overrun_d;
`ifdef LINE_SCALER_SCANLINE_EN
    logic          dim_q, dim_d;
`endif

    logic [PW-1:0] mem [0:2*H_PIXELS-1];
    logic [PW-1:0] rd_word_q;
    logic          wr_en, rd_en, line_end, take_line;
    logic [AW:0]   wr_index, rd_index;

    always_comb begin
        wr_index = {1'b0, wr_addr_q[AW-1:0]};
        if (wr_bank_q) wr_index = WR_LIMIT + {1'b0, wr_addr_q[AW-1:0]};
        rd_index = {1'b0, rd_addr_q};
        if (rd_bank_q) rd_index = WR_LIMIT + {1'b0, rd_addr_q};
    end

    always_comb begin
        wr_en     = in_pix_en && in_valid && (wr_addr_q < WR_LIMIT);
        line_end  = in_pix_en && !in_valid && in_valid_prev_q;
        take_line = out_line_start && (y_rep_q == 3'd0) && (line_ready_q || line_end);
        rd_en     = out_pix_en && out_hactive;

        wr_bank_d       = wr_bank_q;
        rd_bank_d       = rd_bank_q;
        line_ready_d    = line_ready_q;
        wr_addr_d       = wr_addr_q;
        rd_addr_d       = rd_addr_q;
        x_rep_d         = x_rep_q;
        y_rep_d         = y_rep_q;
        in_valid_prev_d = in_valid_prev_q;
        shown_d         = shown_q;
        out_de_d        = out_de_q;
        underrun_d      = 1'b0;
        overrun_d       = overrun_q;
`ifdef LINE_SCALER_SCANLINE_EN
        dim_d           = dim_q;
`endif

        if (in_pix_en) in_valid_prev_d = in_valid;
        if (wr_en) wr_addr_d = wr_addr_q + (AW+1)'(1);
        if (in_pix_en && in_valid && (wr_addr_q >= WR_LIMIT)) overrun_d = 1'b1;
        if (line_end) begin
            wr_bank_d    = ~wr_bank_q;
            line_ready_d = 1'b1;
            wr_addr_d    = '0;
        end

        if (out_line_start) begin
            if (take_line) begin
                // a line finishing this very cycle is newer than any waiting one
                rd_bank_d    = line_end ? wr_bank_q : ~wr_bank_q;
                line_ready_d = 1'b0;
                shown_d      = 1'b1;
            end else if (y_rep_q == 3'd0) begin
                underrun_d = 1'b1;
            end
            rd_addr_d = '0;
            x_rep_d   = 3'd0;
            y_rep_d   = (y_rep_q == Y_LAST) ? 3'd0 : y_rep_q + 3'd1;
        end else if (rd_en) begin
            if (x_rep_q == X_LAST) begin
                x_rep_d = 3'd0;
                if (rd_addr_q != RD_LAST) rd_addr_d = rd_addr_q + AW'(1);
            end else begin
                x_rep_d = x_rep_q + 3'd1;
            end
        end

        if (out_pix_en) begin
            out_de_d = out_hactive && shown_q;
`ifdef LINE_SCALER_SCANLINE_EN
            // y_rep has already advanced past the repetition on screen, so 0 marks the last one
            dim_d = (SCALE_Y > 1) && (y_rep_q == 3'd0);
`endif
        end
    end

    always_ff @(posedge masterclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b1;
            line_ready_q    <= 1'b0;
            wr_addr_q       <= '0;
            rd_addr_q       <= '0;
            x_rep_q         <= 3'd0;
            y_rep_q         <= 3'd0;
            in_valid_prev_q <= 1'b0;
            shown_q         <= 1'b0;
            out_de_q        <= 1'b0;
            underrun_q      <= 1'b0;
            overrun_q       <= 1'b0;
`ifdef LINE_SCALER_SCANLINE_EN
            dim_q           <= 1'b0;
`endif
        end else begin
            wr_bank_q       <= wr_bank_d;
            rd_bank_q       <= rd_bank_d;
            line_ready_q    <= line_ready_d;
            wr_addr_q       <= wr_addr_d;
            rd_addr_q       <= rd_addr_d;
            x_rep_q         <= x_rep_d;
            y_rep_q         <= y_rep_d;
            in_valid_prev_q <= in_valid_prev_d;
            shown_q         <= shown_d;
            out_de_q        <= out_de_d;
            underrun_q      <= underrun_d;
            overrun_q       <= overrun_d;
`ifdef LINE_SCALER_SCANLINE_EN
            dim_q           <= dim_d;
`endif
        end
    end

    // Line buffers: one write port, one registered read port, no reset.
    always_ff @(posedge masterclk) begin
        if (wr_en) mem[wr_index] <= {in_r, in_g, in_b};
        if (rd_en) rd_word_q <= mem[rd_index];
    end

`ifdef LINE_SCALER_SCANLINE_EN
    assign out_r = !out_de_q ? '0 : dim_q ? (rd_word_q[PW-1 -: R_W] >> 1) : rd_word_q[PW-1 -: R_W];
    assign out_g = !out_de_q ? '0 : dim_q ? (rd_word_q[G_W+B_W-1 -: G_W] >> 1) : rd_word_q[G_W+B_W-1 -: G_W];
    assign out_b = !out_de_q ? '0 : dim_q ? (rd_word_q[B_W-1:0] >> 1) : rd_word_q[B_W-1:0];
`else
    assign out_r = out_de_q ? rd_word_q[PW-1 -: R_W] : '0;
    assign out_g = out_de_q ? rd_word_q[G_W+B_W-1 -: G_W] : '0;
    assign out_b = out_de_q ? rd_word_q[B_W-1:0] : '0;
`endif
    assign out_de   = out_de_q;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_line_scaler.sv
// tb/tb_line_scaler.sv - self-checking bench for line_scaler (2x2 and 3x1 instances on shared stimulus)
// Expected pixels come from a line-level model: output pixel j shows stored pixel min(j/SCALE_X, H-1).
module tb_line_scaler;
    localparam int H = 256;

    logic masterclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 masterclk = ~masterclk;

    logic       in_pix_en = 1'b0, in_valid = 1'b0;
    logic [2:0] in_r = 3'd0, in_g = 3'd0;
    logic [1:0] in_b = 2'd0;
    logic       out_pix_en = 1'b0, out_line_start = 1'b0, out_hactive = 1'b0;

    logic [2:0] a_r, a_g, b_r, b_g;
    logic [1:0] a_b, b_b;
    logic       a_de, a_un, a_ov, b_de, b_un, b_ov;

    line_scaler #(.R_W(3), .G_W(3), .B_W(2), .H_PIXELS(H), .SCALE_X(2), .SCALE_Y(2)) dut_a (
        .masterclk(masterclk), .rst_n(rst_n), .in_pix_en(in_pix_en), .in_valid(in_valid),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_pix_en(out_pix_en),
        .out_line_start(out_line_start), .out_hactive(out_hactive),
        .out_r(a_r), .out_g(a_g), .out_b(a_b), .out_de(a_de), .underrun(a_un), .overrun(a_ov));

    line_scaler #(.R_W(3), .G_W(3), .B_W(2), .H_PIXELS(H), .SCALE_X(3), .SCALE_Y(1)) dut_b (
        .masterclk(masterclk), .rst_n(rst_n), .in_pix_en(in_pix_en), .in_valid(in_valid),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_pix_en(out_pix_en),
        .out_line_start(out_line_start), .out_hactive(out_hactive),
        .out_r(b_r), .out_g(b_g), .out_b(b_b), .out_de(b_de), .underrun(b_un), .overrun(b_ov));

    logic [8:0] act_a, act_b;
    assign act_a = {a_de, a_r, a_g, a_b};
    assign act_b = {b_de, b_r, b_g, b_b};

    int total = 0;
    int bad = 0;
    int un_a = 0;
    int un_b = 0;
    always @(posedge masterclk) begin
        if (a_un) un_a++;
        if (b_un) un_b++;
    end

    // model state: index 0 = 2x2 instance, 1 = 3x1 instance
    int         sx [2] = '{2, 3};
    int         sy [2] = '{2, 1};
    logic [7:0] pix [0:299];
    logic [7:0] last_line [0:H-1];
    logic [7:0] m_cur [2][0:H-1];
    bit         m_ready [2];
    bit         m_shown [2];
    int         m_cnt [2];
    int         m_rep [2];
    int         exp_un [2];
    logic [8:0] first_a;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge masterclk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ready[k] = 1'b0;
            m_shown[k] = 1'b0;
            m_cnt[k]   = 0;
        end
    endtask

    task automatic model_line_end();
        for (int i = 0; i < H; i++) last_line[i] = pix[i];
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
    endtask

    task automatic model_start();
        for (int k = 0; k < 2; k++) begin
            exp_un[k] = 0;
            if (m_cnt[k] % sy[k] == 0) begin
                if (m_ready[k]) begin
                    for (int i = 0; i < H; i++) m_cur[k][i] = last_line[i];
                    m_ready[k] = 1'b0;
                    m_shown[k] = 1'b1;
                end else begin
                    exp_un[k] = 1;
                end
            end
            m_rep[k] = m_cnt[k] % sy[k];
            m_cnt[k]++;
        end
    endtask

    function automatic logic [8:0] expo(input int k, input int j);
        logic [7:0] p;
        int idx;
        if (!m_shown[k]) return 9'd0;
        idx = j / sx[k];
        if (idx > H - 1) idx = H - 1;
        p = m_cur[k][idx];
`ifdef LINE_SCALER_SCANLINE_EN
        if (sy[k] > 1 && m_rep[k] == sy[k] - 1) p = {1'b0, p[7:6], 1'b0, p[4:3], 1'b0, p[1]};
`endif
        return {1'b1, p};
    endfunction

    task automatic write_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            in_pix_en = 1'b1;
            in_valid  = 1'b1;
            {in_r, in_g, in_b} = pix[i];
            tick();
            in_pix_en = 1'b0;
        end
    endtask

    task automatic end_line();
        in_pix_en = 1'b1;
        in_valid  = 1'b0;
        tick();
        in_pix_en = 1'b0;
        model_line_end();
    endtask

    task automatic show_line(input int n, input bit simul);
        int ua0, ub0;
        logic [8:0] prev_a, prev_b, e;
        ua0 = un_a;
        ub0 = un_b;
        if (simul) begin
            in_pix_en = 1'b1;
            in_valid  = 1'b0;
            model_line_end();
        end
        out_line_start = 1'b1;
        model_start();
        tick();
        out_line_start = 1'b0;
        in_pix_en = 1'b0;
        prev_a = 9'd0;
        prev_b = 9'd0;
        for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 4) == 0) begin
                tick();
                chk("hold_a", act_a, prev_a);
                chk("hold_b", act_b, prev_b);
            end
            out_pix_en  = 1'b1;
            out_hactive = 1'b1;
            tick();
            out_pix_en  = 1'b0;
            out_hactive = 1'b0;
            e = expo(0, j);
            chk("pix_a", act_a, e);
            prev_a = e;
            e = expo(1, j);
            chk("pix_b", act_b, e);
            prev_b = e;
            if (j == 0) first_a = act_a;
        end
        out_pix_en = 1'b1;
        tick();
        out_pix_en = 1'b0;
        chk("blank_a", act_a, 0);
        chk("blank_b", act_b, 0);
        tick();
        tick();
        chk("underrun_a", un_a - ua0, exp_un[0]);
        chk("underrun_b", un_b - ub0, exp_un[1]);
    endtask

    task automatic random_line();
        for (int i = 0; i < 300; i++) pix[i] = 8'($urandom);
    endtask

    typedef struct {
        logic [7:0] in_px;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;
    vec_t vt [5];

    initial begin
        #10_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vt[0] = '{{3'd7, 3'd6, 2'd3}, {3'd7, 3'd6, 2'd3}, {3'd7, 3'd6, 2'd3}};
        vt[1] = '{{3'd5, 3'd2, 2'd1}, {3'd5, 3'd2, 2'd1}, {3'd5, 3'd2, 2'd1}};
        vt[2] = '{{3'd1, 3'd1, 2'd1}, {3'd1, 3'd1, 2'd1}, {3'd1, 3'd1, 2'd1}};
        vt[3] = '{{3'd0, 3'd0, 2'd0}, {3'd0, 3'd0, 2'd0}, {3'd0, 3'd0, 2'd0}};
        vt[4] = '{{3'd4, 3'd5, 2'd2}, {3'd4, 3'd5, 2'd2}, {3'd4, 3'd5, 2'd2}};
`ifdef LINE_SCALER_SCANLINE_EN
        vt[0].exp1 = {3'd3, 3'd3, 2'd1};
        vt[1].exp1 = {3'd2, 3'd1, 2'd0};
        vt[2].exp1 = {3'd0, 3'd0, 2'd0};
        vt[4].exp1 = {3'd2, 3'd2, 2'd1};
`endif

        model_reset();
        tick();
        tick();
        chk("reset_a_out", act_a, 0);
        chk("reset_b_out", act_b, 0);
        chk("reset_a_flags", {a_un, a_ov}, 0);
        chk("reset_b_flags", {b_un, b_ov}, 0);
        rst_n = 1'b1;
        tick();

        // first output lines after reset: underrun, black
        show_line(40, 1'b0);
        show_line(40, 1'b0);

        // ramp line, second display runs past the end to hit address saturation
        for (int i = 0; i < 300; i++) pix[i] = 8'(i);
        write_pixels(H);
        end_line();
        show_line(512, 1'b0);
        show_line(530, 1'b0);

        for (int r = 0; r < 3; r++) begin
            random_line();
            write_pixels(H);
            end_line();
            show_line(int'($urandom_range(500, 540)), 1'b0);
            show_line(int'($urandom_range(500, 540)), 1'b0);
        end

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 300; i++) pix[i] = vt[v].in_px;
            write_pixels(H);
            end_line();
            show_line(8, 1'b0);
            chk("tbl_rep0", first_a, {1'b1, vt[v].exp0});
            show_line(8, 1'b0);
            chk("tbl_rep1", first_a, {1'b1, vt[v].exp1});
        end

        // no new line: replay previous
        show_line(64, 1'b0);
        show_line(64, 1'b0);

        // overlong line
        chk("overrun_before", a_ov, 0);
        random_line();
        write_pixels(300);
        end_line();
        chk("overrun_a", a_ov, 1);
        chk("overrun_b", b_ov, 1);
        show_line(512, 1'b0);
        show_line(512, 1'b0);
        chk("overrun_sticky", a_ov, 1);

        // line end coincident with out_line_start
        random_line();
        write_pixels(H);
        show_line(512, 1'b1);
        show_line(512, 1'b0);
        show_line(64, 1'b0);
        show_line(64, 1'b0);

        // reset in the middle of an input line
        random_line();
        write_pixels(100);
        rst_n = 1'b0;
        tick();
        chk("midreset_a", {a_ov, a_de, a_un}, 0);
        chk("midreset_b", {b_ov, b_de, b_un}, 0);
        model_reset();
        rst_n = 1'b1;
        in_valid = 1'b0;
        tick();
        show_line(64, 1'b0);
        show_line(64, 1'b0);
        random_line();
        write_pixels(H);
        end_line();
        show_line(520, 1'b0);
        show_line(520, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
